// File: rtl/fifo_pkg.sv
// Shared definitions for the transaction-layer FIFO read side:
// default word width, drain FSM states, skid buffer depth and the pop gate.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int SKID_DEPTH     = 2;
  localparam int CNT_W          = $clog2(SKID_DEPTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // A pop is allowed when the words already held plus the one in flight,
  // minus the one leaving this cycle, still leave a free skid slot.
  function automatic logic can_pop(input logic [CNT_W-1:0] cnt,
                                   input logic             inflight,
                                   input logic             deq);
    logic [CNT_W:0] occ;
    logic [CNT_W:0] lim;
    occ = (CNT_W+1)'(cnt) + (CNT_W+1)'(inflight);
    lim = (CNT_W+1)'(SKID_DEPTH) + (CNT_W+1)'(deq);
    return occ < lim;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry skid buffer: tail write on push, head shift on pop, both in the
// same cycle keep the count and move entry 1 to the head.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CNT_W-1:0]      cnt
);

  logic [DATA_WIDTH-1:0] e0, e1;

  assign dout = e0;

  // Entry storage and occupancy; the upstream pop gate guarantees no push
  // lands on a full buffer unless the head leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == '0) e0 <= din;
          else           e1 <= din;
          cnt <= cnt + CNT_W'(1);
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - CNT_W'(1);
        end
        2'b11: begin
          if (cnt == CNT_W'(1)) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && cnt == CNT_W'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for the transaction-layer FIFO. Decides when to
// pop, captures the returned word a cycle later and hands words downstream
// through a 2-entry skid buffer. Optional FIFO_DRAIN_STATS_EN adds pop and
// stall counters as extra outputs.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int WAIT_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_pop,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  busy
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]           pop_count,
  output logic [15:0]           stall_count
`endif
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

  state_t           state;
  logic [7:0]       wait_cnt;
  logic             pop_q;
  logic [CNT_W-1:0] buf_cnt;
  logic             deq;

  assign out_valid = (buf_cnt != '0);
  assign deq       = out_valid && out_ready;
  assign busy      = (state == DRAIN);
  assign fifo_pop  = (state == DRAIN) && !fifo_empty && can_pop(buf_cnt, pop_q, deq);

  // Drain FSM: go straight to DRAIN when the FIFO is comfortably full,
  // otherwise let a small backlog age for WAIT_CYCLES before forcing it out.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty && !fifo_almost_empty) begin
            state    <= DRAIN;
            wait_cnt <= '0;
          end else if (!fifo_empty) begin
            if (wait_cnt == WAIT_LAST) begin
              state    <= DRAIN;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end else begin
            wait_cnt <= '0;
          end
        end
        DRAIN: begin
          if (fifo_empty && !fifo_pop) begin
            state    <= IDLE;
            wait_cnt <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Marks the cycle in which the FIFO presents the word popped last cycle.
  always_ff @(posedge clk) begin
    if (reset) pop_q <= 1'b0;
    else       pop_q <= fifo_pop;
  end

  skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (pop_q),
    .din   (fifo_data_out),
    .pop   (deq),
    .dout  (out_data),
    .cnt   (buf_cnt)
  );

`ifdef FIFO_DRAIN_STATS_EN
  // Pop counter wraps; stall counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      pop_count   <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_pop) pop_count <= pop_count + 16'd1;
      if (out_valid && !out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

  a_no_pop_on_empty: assert property (@(posedge clk) disable iff (reset)
    !(fifo_pop && fifo_empty));

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: a queue models the FIFO (flags from its size,
// read data one cycle after pop) and a scoreboard holds the words the
// consumer must see, in order.
module tb_fifo_drain_ctrl;

  localparam int DW       = 10;
  localparam int WAIT     = 8;
  localparam int AE_LEVEL = 2;
  localparam int SKID     = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_empty = 1'b1;
  logic          fifo_almost_empty = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_pop;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          busy;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0]   pop_count;
  logic [15:0]   stall_count;
`endif

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.DATA_WIDTH(DW), .WAIT_CYCLES(WAIT)) dut (
    .clk               (clk),
    .reset             (reset),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data_out     (fifo_data_out),
    .fifo_pop          (fifo_pop),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_ready         (out_ready),
    .busy              (busy)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .pop_count         (pop_count),
    .stall_count       (stall_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int cyc_n = 0, pops = 0, acc = 0, peak = 0;
  int first_pop = -1, first_vld = -1, first_acc = -1, last_acc = -1;
  logic          s_pop = 1'b0, s_vld = 1'b0, s_busy = 1'b0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;

  function automatic void set_flags();
    fifo_empty        = (fq.size() == 0);
    fifo_almost_empty = (fq.size() <= AE_LEVEL);
  endfunction

  task automatic load(input int n, input bit rnd);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom) : DW'(i + 1);
      fq.push_back(w);
      exp_q.push_back(w);
    end
    set_flags();
  endtask

  // After a reset, whatever is still in the FIFO is what must come out next.
  task automatic clear_model();
    exp_q = fq;
    pops = 0; acc = 0; peak = 0;
    first_pop = -1; first_vld = -1; first_acc = -1; last_acc = -1;
    hold_pend = 1'b0;
  endtask

  // One clock: observe at the falling edge, then update the FIFO model
  // just after the rising edge.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    cyc_n++;
    s_pop = fifo_pop; s_vld = out_valid; s_busy = busy;
    if (fifo_pop === 1'b1) begin
      checks++;
      if (fifo_empty) begin
        errors++; $display("FAIL pop_on_empty cycle %0d got pop=1 want 0", cyc_n);
      end
      pops++;
      if (first_pop < 0) first_pop = cyc_n;
    end
    if (hold_pend) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold_data) begin
        errors++;
        $display("FAIL hold cycle %0d got v=%0b d=%0d want v=1 d=%0d", cyc_n, out_valid, out_data, hold_data);
      end
    end
    if (out_valid === 1'b1 && first_vld < 0) first_vld = cyc_n;
    if (out_valid === 1'b1 && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL extra_word cycle %0d got %0d want none", cyc_n, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++; $display("FAIL data cycle %0d got %0d want %0d", cyc_n, out_data, e);
        end
      end
      acc++;
      if (first_acc < 0) first_acc = cyc_n;
      last_acc = cyc_n;
    end
    checks++;
    if (pops - acc > SKID) begin
      errors++; $display("FAIL outstanding cycle %0d got %0d want <=%0d", cyc_n, pops - acc, SKID);
    end
    if (int'(dut.buf_cnt) > peak) peak = int'(dut.buf_cnt);
    hold_pend = (out_valid === 1'b1) && !out_ready;
    hold_data = out_data;
    @(posedge clk);
    #1;
    if (s_pop === 1'b1 && fq.size() > 0) begin
      fifo_data_out = fq.pop_front();
      set_flags();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n = 0;
    while (acc < target && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (acc != target) begin
      errors++; $display("FAIL %s_count got %0d want %0d", name, acc, target);
    end
  endtask

  task automatic test_reset();
    fq.delete(); set_flags(); out_ready = 1'b0;
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || fifo_pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0b d=%0d b=%0b p=%0b want all 0", out_valid, out_data, busy, fifo_pop);
    end
`ifdef FIFO_DRAIN_STATS_EN
    checks++;
    if (pop_count !== 16'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", pop_count, stall_count);
    end
`endif
  endtask

  task automatic test_burst();
    apply_reset();
    load(9, 1'b0);
    out_ready = 1'b1;
    run_until(9, 40, "burst");
    checks++;
    if (first_vld - first_pop != 2) begin
      errors++; $display("FAIL burst_latency got %0d want 2", first_vld - first_pop);
    end
    checks++;
    if (last_acc - first_acc != 8) begin
      errors++; $display("FAIL burst_span got %0d want 8", last_acc - first_acc);
    end
    tick(); tick();
    checks++;
    if (s_busy !== 1'b0 || s_pop !== 1'b0) begin
      errors++; $display("FAIL burst_idle got busy=%0b pop=%0b want 0 0", s_busy, s_pop);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    load(9, 1'b1);
    out_ready = 1'b1;
    run_until(3, 20, "bp_head");
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    run_until(9, 40, "bp");
    checks++;
    if (peak != SKID) begin
      errors++; $display("FAIL bp_peak got %0d want %0d", peak, SKID);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL bp_left got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_forced_drain();
    int fall;
    apply_reset();
    out_ready = 1'b1;
    repeat (3) tick();
    load(2, 1'b1);
    fall = cyc_n + 1;
    run_until(2, 30, "forced");
    checks++;
    if (first_pop - fall != WAIT) begin
      errors++; $display("FAIL forced_wait got %0d want %0d", first_pop - fall, WAIT);
    end
  endtask

  task automatic test_empty();
    apply_reset();
    out_ready = 1'b1;
    repeat (20) begin
      tick();
      checks++;
      if (s_pop !== 1'b0 || s_vld !== 1'b0 || s_busy !== 1'b0) begin
        errors++; $display("FAIL empty_idle got p=%0b v=%0b b=%0b want 0 0 0", s_pop, s_vld, s_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int left;
    apply_reset();
    load(9, 1'b1);
    out_ready = 1'b0;
    while (int'(dut.buf_cnt) != 2 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (int'(dut.buf_cnt) != 2) begin
      errors++; $display("FAIL rst_mid_fill got %0d want 2", dut.buf_cnt);
    end
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || fifo_pop !== 1'b0 || dut.buf_cnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_clear got v=%0b d=%0d b=%0b p=%0b c=%0d want all 0", out_valid, out_data, busy, fifo_pop, dut.buf_cnt);
    end
    left = fq.size();
    out_ready = 1'b1;
    run_until(left, 40, "rst_mid_restart");
  endtask

  task automatic test_random();
    int n, target, budget;
    apply_reset();
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 12);
      load(n, 1'b1);
      target = acc + n;
      budget = 0;
      while (acc < target && budget < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        tick();
        budget++;
      end
      checks++;
      if (acc != target) begin
        errors++; $display("FAIL random_round%0d got %0d want %0d", r, acc, target);
      end
      out_ready = 1'b1;
      repeat ($urandom_range(0, 4)) tick();
    end
  endtask

`ifdef FIFO_DRAIN_STATS_EN
  task automatic test_stats();
    apply_reset();
    load(9, 1'b1);
    out_ready = 1'b1;
    run_until(3, 20, "stats_head");
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    run_until(9, 40, "stats");
    tick(); tick();
    checks++;
    if (pop_count !== 16'd9) begin
      errors++; $display("FAIL stats_pop got %0d want 9", pop_count);
    end
    checks++;
    if (stall_count !== 16'd3) begin
      errors++; $display("FAIL stats_stall got %0d want 3", stall_count);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_forced_drain();
    test_empty();
    test_reset_mid();
    test_random();
`ifdef FIFO_DRAIN_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
